// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit, retiring UNROLL result bits per cycle
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PREP = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8) || XLEN % UNROLL != 0 || XLEN < 2) begin : g_bad_cfg
        $error("muldiv_unit: UNROLL must be 1, 2, 4 or 8 and divide XLEN");
    end

    logic [2:0]        state, f3;
    logic [XLEN-1:0]   a, b, hi, lo, d, nh, nl;
    logic [XLEN-1:0]   mag_a, mag_b, q, rm, short_res, fix_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     t, r;
    logic [CW-1:0]     cnt;
    logic              is_div, sa, sb, neg, div_zero, ovf;

    // a and b stay frozen for the whole operation, so signs are derived from them on demand
    assign is_div    = f3[2];
    assign sa        = a[XLEN-1] & (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6);
    assign sb        = b[XLEN-1] & (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
    assign neg       = sa ^ sb;
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;
    assign div_zero  = b == '0;
    assign ovf       = !f3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign short_res = f3[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
    assign prod      = neg ? -{hi, lo} : {hi, lo};
    assign q         = neg ? -lo : lo;
    assign rm        = sa ? -hi : hi;
    assign fix_res   = is_div ? (f3[1] ? rm : q) : (f3 == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign busy      = state == PREP || state == CALC || state == FIX;
    assign done      = state == DONE;

    // {hi, lo} is the shift-add product register or the {remainder, dividend/quotient} pair
    always_comb begin
        nh = hi;
        nl = lo;
        t  = '0;
        r  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div) begin
                r  = {nh, nl[XLEN-1]};
                t  = {XLEN'(0), r >= {1'b0, d}};
                r  = t[0] ? r - {1'b0, d} : r;
                nh = r[XLEN-1:0];
                nl = {nl[XLEN-2:0], t[0]};
            end else begin
                t  = {1'b0, nh} + (nl[0] ? {1'b0, d} : '0);
                nh = t[XLEN:1];
                nl = {t[0], nl[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            f3     <= '0;
            a      <= '0;
            b      <= '0;
            hi     <= '0;
            lo     <= '0;
            d      <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= start ? PREP : IDLE;
                    if (start) begin
                        f3 <= funct3;
                        a  <= op_a;
                        b  <= op_b;
                    end
                end
                PREP: begin
                    if (is_div && (div_zero || ovf)) begin
                        result <= short_res;
                        state  <= DONE;
                    end else begin
                        hi    <= '0;
                        lo    <= mag_a;
                        d     <= mag_b;
                        cnt   <= CW'(N);
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi    <= nh;
                    lo    <= nl;
                    cnt   <= cnt - 1'b1;
                    state <= cnt == CW'(1) ? FIX : CALC;
                end
                FIX: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit (UNROLL 1 and 4) against a latency/arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start, kill, busy, done;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] res [2];
    int          pass_cnt = 0;
    int          total = 0;

    bit          armed = 1'b0;
    bit          infl [2];
    int          age [2];
    int          lat [2];
    logic [31:0] pres [2];
    logic [31:0] eres [2];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
        .clk(clk), .reset(reset), .start(start[0]), .funct3(f3), .op_a(a), .op_b(b),
        .kill(kill[0]), .busy(busy[0]), .done(done[0]), .result(res[0])
    );

    muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
        .clk(clk), .reset(reset), .start(start[1]), .funct3(f3), .op_a(a), .op_b(b),
        .kill(kill[1]), .busy(busy[1]), .done(done[1]), .result(res[1])
    );

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy;
        logic [63:0] p;
        bit         ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ov = x == 32'h80000000 && y == 32'hFFFFFFFF;
        case (f)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * longint'({32'd0, y})); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: return y == 32'd0 ? 32'hFFFFFFFF : ov ? x : 32'(sx / sy);
            3'd5: return y == 32'd0 ? 32'hFFFFFFFF : x / y;
            3'd6: return y == 32'd0 ? x : ov ? 32'd0 : 32'(sx % sy);
            default: return y == 32'd0 ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input int k, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)))
            return 2;
        return 32 / (k == 1 ? 4 : 1) + 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference: an accepted request finishes lat cycles later unless reset or kill intervenes
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                infl[k] <= 1'b0;
                eres[k] <= 32'd0;
                armed   <= 1'b1;
            end else if (kill[k]) begin
                infl[k] <= 1'b0;
            end else if (!infl[k] || age[k] == lat[k]) begin
                infl[k] <= start[k];
                if (start[k]) begin
                    age[k]  <= 1;
                    lat[k]  <= lat_of(k, f3, a, b);
                    pres[k] <= ref_op(f3, a, b);
                end
            end else begin
                age[k] <= age[k] + 1;
                if (age[k] + 1 == lat[k]) eres[k] <= pres[k];
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk(k == 1 ? "u4 busy" : "u1 busy", 64'(busy[k]), 64'(infl[k] && age[k] < lat[k]));
                chk(k == 1 ? "u4 done" : "u1 done", 64'(done[k]), 64'(infl[k] && age[k] == lat[k]));
                chk(k == 1 ? "u4 result" : "u1 result", 64'(res[k]), 64'(eres[k]));
            end
        end
    end

    task automatic run(input int k, input logic [2:0] fv, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ex, input int el, input bit poke);
        int n;
        chk($sformatf("model f%0d %0h %0h", fv, av, bv), 64'(ref_op(fv, av, bv)), 64'(ex));
        f3 = fv;
        a = av;
        b = bv;
        start[k] = 1'b1;
        tick;
        n = 1;
        while (!done[k] && n < 100) begin
            start[k] = poke && n == 5;
            f3 = 3'($urandom);
            a = $urandom;
            b = $urandom;
            tick;
            n++;
        end
        start[k] = 1'b0;
        chk($sformatf("latency u%0d f%0d", k, fv), 64'(n), 64'(el));
        chk($sformatf("result u%0d f%0d %0h %0h", k, fv, av, bv), 64'(res[k]), 64'(ex));
        tick;
    endtask

    initial begin
        int n;
        logic [31:0] prev;
        reset = 1'b1;
        start = '0;
        kill = '0;
        f3 = '0;
        a = '0;
        b = '0;
        repeat (2) tick;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset result u1", 64'(res[0]), 64'(0));
        chk("reset result u4", 64'(res[1]), 64'(0));
        reset = 1'b0;
        tick;
        run(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 35, 1'b1);
        run(0, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 35, 1'b0);
        run(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1'b0);
        run(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 1'b0);
        for (int k = 0; k < 2; k++) begin
            run(k, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, k == 1 ? 11 : 35, 1'b0);
            run(k, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, k == 1 ? 11 : 35, 1'b0);
            run(k, 3'd5, 32'd100, 32'd7, 32'd14, k == 1 ? 11 : 35, 1'b0);
            run(k, 3'd7, 32'd100, 32'd7, 32'd2, k == 1 ? 11 : 35, 1'b0);
            run(k, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, k == 1 ? 11 : 35, 1'b0);
            run(k, 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 2, 1'b0);
            run(k, 3'd7, 32'd5, 32'd0, 32'd5, 2, 1'b0);
            run(k, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
            run(k, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2, 1'b0);
        end
        prev = res[0];
        f3 = 3'd4;
        a = 32'd100;
        b = 32'd7;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (9) tick;
        kill[0] = 1'b1;
        tick;
        kill[0] = 1'b0;
        chk("kill busy", 64'(busy[0]), 64'(0));
        chk("kill done", 64'(done[0]), 64'(0));
        chk("kill result", 64'(res[0]), 64'(prev));
        repeat (40) tick;
        kill[0] = 1'b1;
        start[0] = 1'b1;
        f3 = 3'd0;
        a = 32'd1;
        b = 32'd1;
        tick;
        kill[0] = 1'b0;
        start[0] = 1'b0;
        chk("kill+start dropped", 64'(busy[0]), 64'(0));
        run(0, 3'd0, 32'd3, 32'd4, 32'd12, 35, 1'b0);
        f3 = 3'd5;
        a = 32'd1000;
        b = 32'd3;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (19) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midreset busy", 64'(busy[0]), 64'(0));
        chk("midreset done", 64'(done[0]), 64'(0));
        chk("midreset result", 64'(res[0]), 64'(0));
        f3 = 3'd5;
        a = 32'd9;
        b = 32'd3;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        n = 1;
        while (!done[0] && n < 100) begin
            tick;
            n++;
        end
        chk("b2b first latency", 64'(n), 64'(35));
        chk("b2b first result", 64'(res[0]), 64'(3));
        f3 = 3'd3;
        a = 32'd2;
        b = 32'd3;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        chk("b2b no bubble", 64'(busy[0]), 64'(1));
        n = 1;
        while (!done[0] && n < 100) begin
            tick;
            n++;
        end
        chk("b2b second latency", 64'(n), 64'(35));
        chk("b2b second result", 64'(res[0]), 64'(0));
        repeat (3) tick;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised integer multiply/divide execution unit implementing the eight RISC-V M-extension operations for the multi-cycle core. The core's control unit issues a one-cycle `start` with operands and `funct3`, stalls while `busy` is high, and writes `result` to rd when `done` pulses. Throughput is set by `UNROLL`, the number of result bits retired per cycle. Divide-by-zero and signed overflow take a short path.

## Interface
- `XLEN`, 32: operand and result width.
- `UNROLL`, 1: bits processed per CALC cycle. Legal values are 1, 2, 4 or 8, and `XLEN % UNROLL` must be 0; any other setting must fail elaboration.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `start` in 1: request; sampled only in IDLE or DONE.
- `funct3` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a` in XLEN: rs1 value (multiplicand or dividend).
- `op_b` in XLEN: rs2 value (multiplier or divisor).
- `kill` in 1: abort the operation in flight (trap or interrupt).
- `busy` out 1: high in PREP, CALC and FIX.
- `done` out 1: one-cycle pulse in DONE; `result` is valid in that cycle.
- `result` out XLEN: registered result, held until the next `done`.

## Operation
- **States:** IDLE, PREP, CALC, FIX, DONE.
- **IDLE/DONE + start:** go to PREP. Capture `op_a`, `op_b` and `funct3` on the same edge. While in PREP/CALC/FIX, input changes are ignored.
- **PREP:**
  - Record the sign of each operand. `op_a` is signed for MULH, MULHSU, DIV and REM. `op_b` is signed for MULH, DIV and REM.
  - Replace each signed operand with its absolute value (XLEN+1-bit internal magnitude, so `0x80000000` is handled).
  - Load the counter with `XLEN/UNROLL`, then go to CALC.
  - **Short path, PREP goes straight to DONE instead:**
    - Divisor = 0: quotient = all ones; remainder = `op_a` unchanged.
    - DIV/REM with `op_a` = signed minimum and `op_b` = −1: quotient = `op_a`; remainder = 0.
- **CALC:**
  - Multiply: shift-add of `UNROLL` multiplier bits per cycle into a 2·XLEN accumulator.
  - Divide: restoring division, `UNROLL` quotient bits per cycle, remainder XLEN+1 bits.
  - The counter decrements each cycle; when it reaches 1, go to FIX.
- **FIX:**
  - Product: negate the 2·XLEN product if the operand signs differ.
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Select the output: MUL takes the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits. Register it into `result`, then go to DONE.
- **DONE:** `done` = 1. Without `start` go to IDLE; with `start` go to PREP (back-to-back issue).
- **Priority:** reset > kill > start.
  - `kill` in any state: next state IDLE, no `done`, `result` unchanged.
  - `kill` together with `start` in IDLE/DONE: the request is dropped.
- **Arithmetic:** all arithmetic is modulo 2^XLEN or 2^(2·XLEN); no exceptions are raised.

## Timing
- **Reset values:** state IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0. Internal operand registers are zeroed.
- **Reset mid-operation:** IDLE on the next edge, no `done`.
- **Normal latency:** let N = XLEN/UNROLL and let `start` be sampled high in cycle 0.
  - Cycle 1: PREP.
  - Cycles 2..N+1: CALC.
  - Cycle N+2: FIX.
  - Cycle N+3: DONE, `done` = 1.
  - So N+3 cycles in total: 35 for 32/1 and 11 for 32/4.
- **Short-path latency:** `done` in cycle 2.
- **`busy` timing:** `busy` rises in cycle 1 and falls in the DONE cycle. `busy` and `done` are never high together.
- **Back-to-back:** `start` in the DONE cycle puts PREP in the next cycle, with no idle bubble.
- **Result stability:** `result` changes only on the edge entering DONE.

## Test plan
- **MUL:** `funct3`=0, `op_a`=7, `op_b`=0xFFFFFFFD → `result` 0xFFFFFFEB, `done` in cycle 35, `busy` high cycles 1–34.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- **Divides:**
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - All at cycle 35; repeat with `UNROLL`=4 and check `done` at cycle 11.
- **Short path:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All with `done` in cycle 2.
- **Kill and reset:** `kill` in cycle 10 of a DIV → `busy` low in cycle 11, no `done`, `result` unchanged; a new MUL 3×4 then returns 12. Reset in cycle 20 → all outputs 0 next cycle.
- **Back-to-back:** `start` held in the DONE cycle with new operands (MULHU 2×3 after DIVU 9/3) → `results` 3 and then 0, with no bubble. `start` during `busy` is ignored.
